// File: rtl/demux12.sv
// demux12: routes whole packets from stream A to one of two registered
// outputs, chosen by S on the first beat, with per-output packet counters.
module demux12 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic             A_valid,
   input  logic             A_last,
   output logic             A_ready,
   input  logic             S,
   output logic [WIDTH-1:0] Y0,
   output logic             Y0_valid,
   output logic             Y0_last,
   input  logic             Y0_ready,
   output logic [WIDTH-1:0] Y1,
   output logic             Y1_valid,
   output logic             Y1_last,
   input  logic             Y1_ready,
   output logic [7:0]       P0,
   output logic [7:0]       P1
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUTE0 = 2'd1,
      ROUTE1 = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             tgt;
   logic             accept;

   logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d;
   logic             y0_valid_q, y0_valid_d;
   logic             y1_valid_q, y1_valid_d;
   logic             y0_last_q, y0_last_d;
   logic             y1_last_q, y1_last_d;
   logic [7:0]       p0_q, p0_d, p1_q, p1_d;
   logic             load0, load1;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: lock onto the destination until the last beat
   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (A_last) begin
            state_d = IDLE;
         end else begin
            state_d = tgt ? ROUTE1 : ROUTE0;
         end
      end
   end

   // FSM outputs: target select and upstream ready
   always_comb begin
      tgt = S;
      unique case (state_q)
         IDLE:    tgt = S;
         ROUTE0:  tgt = 1'b0;
         ROUTE1:  tgt = 1'b1;
         default: tgt = S;
      endcase
      A_ready = 1'b0;
      if (rst_n) begin
         A_ready = tgt ? (~y1_valid_q | Y1_ready)
                       : (~y0_valid_q | Y0_ready);
      end
      accept = A_valid & A_ready;
      load0  = accept & ~tgt;
      load1  = accept &  tgt;
   end

   // Output slots: load on accept, else drain on downstream ready
   always_comb begin
      y0_d       = y0_q;
      y0_last_d  = y0_last_q;
      y0_valid_d = y0_valid_q;
      y1_d       = y1_q;
      y1_last_d  = y1_last_q;
      y1_valid_d = y1_valid_q;
      p0_d       = p0_q;
      p1_d       = p1_q;
      if (load0) begin
         y0_d       = A;
         y0_last_d  = A_last;
         y0_valid_d = 1'b1;
         if (A_last) p0_d = p0_q + 8'd1;
      end else if (y0_valid_q && Y0_ready) begin
         y0_valid_d = 1'b0;
      end
      if (load1) begin
         y1_d       = A;
         y1_last_d  = A_last;
         y1_valid_d = 1'b1;
         if (A_last) p1_d = p1_q + 8'd1;
      end else if (y1_valid_q && Y1_ready) begin
         y1_valid_d = 1'b0;
      end
   end

   // Output and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y0_q       <= '0;
         y0_last_q  <= 1'b0;
         y0_valid_q <= 1'b0;
         y1_q       <= '0;
         y1_last_q  <= 1'b0;
         y1_valid_q <= 1'b0;
         p0_q       <= 8'd0;
         p1_q       <= 8'd0;
      end else begin
         y0_q       <= y0_d;
         y0_last_q  <= y0_last_d;
         y0_valid_q <= y0_valid_d;
         y1_q       <= y1_d;
         y1_last_q  <= y1_last_d;
         y1_valid_q <= y1_valid_d;
         p0_q       <= p0_d;
         p1_q       <= p1_d;
      end
   end

   assign Y0       = y0_q;
   assign Y0_last  = y0_last_q;
   assign Y0_valid = y0_valid_q;
   assign Y1       = y1_q;
   assign Y1_last  = y1_last_q;
   assign Y1_valid = y1_valid_q;
   assign P0       = p0_q;
   assign P1       = p1_q;

endmodule

// File: tb/tb_demux12.sv
// tb_demux12: directed packets against a packet-level reference model,
// compared every cycle, plus literal expectations per scenario.
module tb_demux12;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] A = '0;
   logic         A_valid = 1'b0;
   logic         A_last = 1'b0;
   logic         A_ready;
   logic         S = 1'b0;
   logic [W-1:0] Y0, Y1;
   logic         Y0_valid, Y1_valid, Y0_last, Y1_last;
   logic         Y0_ready = 1'b1;
   logic         Y1_ready = 1'b1;
   logic [7:0]   P0, P1;

   int checks = 0;
   int errors = 0;

   demux12 #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .A(A), .A_valid(A_valid), .A_last(A_last), .A_ready(A_ready),
      .S(S),
      .Y0(Y0), .Y0_valid(Y0_valid), .Y0_last(Y0_last), .Y0_ready(Y0_ready),
      .Y1(Y1), .Y1_valid(Y1_valid), .Y1_last(Y1_last), .Y1_ready(Y1_ready),
      .P0(P0), .P1(P1)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Reference: each output is a one-entry slot; a packet owns a
   // destination from its first beat until its last beat is taken.
   logic [W-1:0] md [2];
   logic         mv [2];
   logic         ml [2];
   logic [7:0]   mp [2];
   int           owner;
   int           t;
   logic         e_rdy, e_acc;
   logic         yr [2];

   always_comb begin
      yr[0] = Y0_ready;
      yr[1] = Y1_ready;
      t = (owner < 0) ? int'(S) : owner;
      e_rdy = rst_n && (!mv[t] || yr[t]);
      e_acc = A_valid && e_rdy;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            md[k] <= '0;
            mv[k] <= 1'b0;
            ml[k] <= 1'b0;
            mp[k] <= 8'd0;
         end
         owner <= -1;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (e_acc && t == k) begin
               md[k] <= A;
               ml[k] <= A_last;
               mv[k] <= 1'b1;
               if (A_last) mp[k] <= 8'((int'(mp[k]) + 1) % 256);
            end else if (mv[k] && yr[k]) begin
               mv[k] <= 1'b0;
            end
         end
         if (e_acc) owner <= A_last ? -1 : t;
      end
   end

   always @(negedge clk) begin
      check("A_ready", 32'(A_ready), 32'(e_rdy));
      check("Y0_valid", 32'(Y0_valid), 32'(mv[0]));
      check("Y1_valid", 32'(Y1_valid), 32'(mv[1]));
      check("Y0", 32'(Y0), 32'(md[0]));
      check("Y1", 32'(Y1), 32'(md[1]));
      check("Y0_last", 32'(Y0_last), 32'(ml[0]));
      check("Y1_last", 32'(Y1_last), 32'(ml[1]));
      check("P0", 32'(P0), 32'(mp[0]));
      check("P1", 32'(P1), 32'(mp[1]));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [W-1:0] d, input logic l,
                       input logic s);
      A = d;
      A_valid = 1'b1;
      A_last = l;
      S = s;
      tick();
   endtask

   task automatic idle();
      A_valid = 1'b0;
      A_last = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      A_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      tick();
      tick();
      check("rst A_ready", 32'(A_ready), 32'h0);
      check("rst Y0_valid", 32'(Y0_valid), 32'h0);
      check("rst P0", 32'(P0), 32'h0);
      rst_n = 1'b1;

      // three-beat packet to Y0
      beat(8'h11, 1'b0, 1'b0);
      check("s1 Y0 b0", 32'(Y0), 32'h11);
      check("s1 last b0", 32'(Y0_last), 32'h0);
      beat(8'h22, 1'b0, 1'b0);
      check("s1 Y0 b1", 32'(Y0), 32'h22);
      beat(8'h33, 1'b1, 1'b0);
      check("s1 Y0 b2", 32'(Y0), 32'h33);
      check("s1 last b2", 32'(Y0_last), 32'h1);
      check("s1 Y1_valid", 32'(Y1_valid), 32'h0);
      check("s1 P0", 32'(P0), 32'h1);
      idle();
      check("s1 drained", 32'(Y0_valid), 32'h0);

      // S flips mid-packet: packet stays on Y0
      beat(8'h44, 1'b0, 1'b0);
      beat(8'h55, 1'b0, 1'b1);
      check("s2 Y0 b1", 32'(Y0), 32'h55);
      beat(8'h66, 1'b1, 1'b1);
      check("s2 Y0 b2", 32'(Y0), 32'h66);
      check("s2 Y1_valid", 32'(Y1_valid), 32'h0);
      check("s2 P0", 32'(P0), 32'h2);
      beat(8'h77, 1'b1, 1'b1);
      check("s2 Y1", 32'(Y1), 32'h77);
      check("s2 Y1_valid n", 32'(Y1_valid), 32'h1);
      idle();

      // backpressure on Y1 then release with no bubble
      Y1_ready = 1'b0;
      beat(8'hAA, 1'b1, 1'b1);
      A = 8'hBB;
      #1;
      check("s3 A_ready lo", 32'(A_ready), 32'h0);
      tick();
      check("s3 Y1 hold", 32'(Y1), 32'hAA);
      Y1_ready = 1'b1;
      #1;
      check("s3 A_ready hi", 32'(A_ready), 32'h1);
      tick();
      check("s3 Y1 new", 32'(Y1), 32'hBB);
      check("s3 Y1_valid", 32'(Y1_valid), 32'h1);
      idle();

      // reset in the middle of a packet to Y1
      beat(8'h90, 1'b0, 1'b1);
      A = 8'h91;
      #2;
      rst_n = 1'b0;
      #1;
      check("s5 Y1_valid", 32'(Y1_valid), 32'h0);
      check("s5 P0", 32'(P0), 32'h0);
      check("s5 P1", 32'(P1), 32'h0);
      check("s5 A_ready", 32'(A_ready), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // alternating single-beat packets 0,1,0
      beat(8'h01, 1'b1, 1'b0);
      check("s4 Y0 first", 32'(Y0), 32'h01);
      check("s4 Y0_valid", 32'(Y0_valid), 32'h1);
      beat(8'h02, 1'b1, 1'b1);
      check("s4 Y1", 32'(Y1), 32'h02);
      beat(8'h03, 1'b1, 1'b0);
      check("s4 Y0 third", 32'(Y0), 32'h03);
      idle();
      check("s4 P0", 32'(P0), 32'h2);
      check("s4 P1", 32'(P1), 32'h1);

      // counter wrap after 256 packets to Y0
      do_reset();
      for (int i = 0; i < 256; i++) begin
         beat(8'(i), 1'b1, 1'b0);
         if (i == 254) check("s6 P0 255", 32'(P0), 32'd255);
      end
      idle();
      check("s6 P0 wrap", 32'(P0), 32'h0);
      check("s6 P1", 32'(P1), 32'h0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux12.md
DEMUX12 -- requirements
Module: demux12

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data beat width in bits.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port A, input, WIDTH: input data beat.
REQ-005 SHALL have port A_valid, input, 1: input beat valid.
REQ-006 SHALL have port A_last, input, 1: final beat of the packet.
REQ-007 SHALL have port A_ready, output, 1: beat accepted this cycle when A_valid is also high.
REQ-008 SHALL have port S, input, 1: destination select (0 -> Y0, 1 -> Y1), sampled on the first beat of each packet.
REQ-009 SHALL have ports Y0 and Y1, output, WIDTH each: registered output data.
REQ-010 SHALL have ports Y0_valid and Y1_valid, output, 1 each: output beat valid.
REQ-011 SHALL have ports Y0_last and Y1_last, output, 1 each: output last flag.
REQ-012 SHALL have ports Y0_ready and Y1_ready, input, 1 each: downstream ready.
REQ-013 SHALL have ports P0 and P1, output, 8 each: count of completed packets routed to each output.

Function
REQ-014 SHALL implement an FSM with states IDLE, ROUTE0 and ROUTE1.
REQ-015 SHALL define target t as follows: in IDLE, t = S; in ROUTEk, t = k.
REQ-016 SHALL define accept = A_valid & A_ready.
REQ-017 SHALL drive A_ready = ~Yt_valid | Yt_ready, combinationally, forced to 0 while rst_n is low.
REQ-018 SHALL, on accept, load Yt <= A and Yt_last <= A_last, and set Yt_valid <= 1 at the next edge (latency 1 cycle).
REQ-019 SHALL clear Yk_valid when Yk_valid & Yk_ready and no new load to output k occurs in the same cycle; a simultaneous drain and load keeps Yk_valid at 1 with the new data.
REQ-020 SHALL hold Yk and Yk_last stable while Yk_valid & ~Yk_ready.
REQ-021 SHALL transition the FSM as follows: IDLE + accept + ~A_last -> ROUTE(S); IDLE + accept + A_last -> IDLE (single-beat packet); ROUTEk + accept + A_last -> IDLE; all other cases hold state.
REQ-022 SHALL ignore changes on S while in ROUTE0 or ROUTE1; a packet never splits across outputs.
REQ-023 SHALL leave the non-target output register untouched, so it may drain concurrently.
REQ-024 SHALL sustain throughput of 1 beat per cycle while Yt_ready is held high.
REQ-025 SHALL increment Pk on accept of an A_last beat routed to k; it wraps 255 -> 0 with no saturation.
REQ-026 SHALL NOT require A_valid to drop between packets; back-to-back packets to different outputs are legal, with the new S taken in IDLE.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force: state IDLE, Y0_valid = Y1_valid = 0, Y0 = Y1 = 0, Y0_last = Y1_last = 0, P0 = P1 = 0, A_ready = 0.
REQ-028 SHALL, on reset mid-packet, discard the partial packet and buffered beats; after release the first accepted beat samples S afresh.
REQ-029 SHALL release reset synchronously to clk (deassertion-edge timing is the integrator's responsibility); first accept is possible in the first cycle after release.

Verification
REQ-030 SHALL verify this scenario: S=0, 3-beat packet 0x11, 0x22, 0x33 (last on 0x33), Y0_ready=1 -> Y0 shows 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle after the first accept, Y0_last only with 0x33, Y1_valid stays 0, P0=1.
REQ-031 SHALL verify this scenario: S toggled to 1 during the second beat of a 3-beat packet started with S=0 -> all 3 beats appear on Y0 and nothing on Y1; the next packet with S=1 goes to Y1.
REQ-032 SHALL verify this scenario: Y1_ready=0 with Y1_valid=1 holding 0xAA, and a new beat targeting Y1 -> A_ready=0 and Y1 holds 0xAA; raising Y1_ready gives accept in the same cycle and 0xAA is replaced by the new beat next cycle with no bubble.
REQ-033 SHALL verify this scenario: alternating single-beat packets 0->1->0 with both readies high -> one beat per cycle, P0=2, P1=1.
REQ-034 SHALL verify this scenario: rst_n pulsed low during the second beat of a packet to Y1 -> Y1_valid=0 immediately, counters 0, and the next packet with S=0 routes to Y0.
REQ-035 SHALL verify this scenario: 256 single-beat packets to Y0 -> P0 wraps to 0 and P1 remains 0.
